// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// ----------------
// Shares the DDR controller command interface between NUM_PORTS clients.
// One command is in flight at a time (IDLE -> ISSUE -> WAIT). Reads record
// the issuing port in a tag FIFO so returning data is routed back in order.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req/we/addr/wdata  : per-port request (flat packed, port i at slice i)
//   ack                : one-cycle pulse when the port's command is accepted
//   rd_valid, rd_data  : routed read return (rd_data shared by all ports)
//   busy               : arbiter not idle, or controller not initialised
//   err_orphan         : sticky, read data arrived with no pending tag
//   init_done, cmd_busy, ddr_data_valid, ddr_rd_data : from controller
//   cmd, cmd_valid, ddr_address, ddr_wr_data        : to controller
module ddr_port_arbiter #(
    parameter int         NUM_PORTS       = 4,
    parameter int         ADDR_W          = 25,
    parameter int         DATA_W          = 128,
    parameter int         PRIO_MODE       = 0,
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [3:0] CMD_RD          = 4'h1,
    parameter logic [3:0] CMD_WR          = 4'h2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [NUM_PORTS-1:0]        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        busy,
    output logic                        err_orphan,
    input  logic                        init_done,
    input  logic                        cmd_busy,
    input  logic                        ddr_data_valid,
    input  logic [DATA_W-1:0]           ddr_rd_data,
    output logic [3:0]                  cmd,
    output logic                        cmd_valid,
    output logic [ADDR_W-1:0]           ddr_address,
    output logic [DATA_W-1:0]           ddr_wr_data
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(MAX_OUTSTANDING);
    localparam logic [TW:0] TAG_DEPTH = (TW+1)'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]           state;
    logic [PW-1:0]        last;
    logic [PW-1:0]        winner;
    logic                 win_rd;
    logic [PW-1:0]        sel;
    logic                 sel_found;
    logic [NUM_PORTS-1:0] elig;
    logic [PW-1:0]        rr_idx [NUM_PORTS];

    logic [PW-1:0]        tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]        wr_ptr;
    logic [TW-1:0]        rd_ptr;
    logic [TW:0]          tag_cnt;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 accept;
    logic                 push;
    logic                 pop;

    assign tag_full  = (tag_cnt == TAG_DEPTH);
    assign tag_empty = (tag_cnt == '0);
    assign accept    = (state == S_ISSUE) && !cmd_busy;
    assign push      = accept && win_rd;
    assign pop       = ddr_data_valid && !tag_empty;
    assign cmd_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE) || !init_done;

    // Per-port eligibility and round-robin search order. A full tag FIFO
    // only blocks reads, so writes can still overtake a stalled read.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign elig[k]   = req[k] && (we[k] || !tag_full);
        assign rr_idx[k] = PW'((32'(last) + k + 1) % NUM_PORTS);
    end

    // Winner selection, evaluated every cycle but only used in IDLE.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        if (PRIO_MODE != 0) begin
            // Descending scan: the lowest eligible index is written last.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    sel       = PW'(i);
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!sel_found && elig[rr_idx[k]]) begin
                    sel       = rr_idx[k];
                    sel_found = 1'b1;
                end
            end
        end
    end

    // Ack is coincident with the controller accepting the command.
    always_comb begin
        ack = '0;
        if (accept)
            ack[winner] = 1'b1;
    end

    // Command FSM. Once a command is latched it always finishes its
    // handshake; init_done only gates the next selection in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last        <= PW'(NUM_PORTS - 1);
            winner      <= '0;
            win_rd      <= 1'b0;
            cmd         <= '0;
            ddr_address <= '0;
            ddr_wr_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (init_done && !cmd_busy && sel_found) begin
                        winner      <= sel;
                        win_rd      <= !we[sel];
                        cmd         <= we[sel] ? CMD_WR : CMD_RD;
                        ddr_address <= addr[sel*ADDR_W +: ADDR_W];
                        ddr_wr_data <= wdata[sel*DATA_W +: DATA_W];
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!cmd_busy) begin
                        last  <= winner;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!cmd_busy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag FIFO pointers. Push and pop in the same cycle leave the count
    // unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Tag storage needs no reset; entries are only read behind wr_ptr.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= winner;
    end

    // Read return: one register stage from ddr_data_valid to rd_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= '0;
            rd_data    <= '0;
            err_orphan <= 1'b0;
        end else begin
            rd_valid <= '0;
            if (pop) begin
                rd_valid[tag_mem[rd_ptr]] <= 1'b1;
                rd_data                   <= ddr_rd_data;
            end
            if (ddr_data_valid && tag_empty)
                err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter. Two instances share all inputs:
// dut_a is round-robin, dut_p is fixed priority. Expected grants and
// read-return routing are queued when stimulus is set up and popped when
// the DUT acks / returns data.
module tb_ddr_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 128;
    localparam logic [3:0] CMD_RD = 4'h1;
    localparam logic [3:0] CMD_WR = 4'h2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, init_done, cmd_busy, ddr_data_valid;
    logic [NP-1:0]    req, we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [DW-1:0]    ddr_rd_data;

    logic [NP-1:0] ack_a, rd_valid_a, ack_p, rd_valid_p;
    logic [DW-1:0] rd_data_a, rd_data_p, ddr_wr_data_a, ddr_wr_data_p;
    logic          busy_a, busy_p, err_a, err_p, cmd_valid_a, cmd_valid_p;
    logic [3:0]    cmd_a, cmd_p;
    logic [AW-1:0] ddr_address_a, ddr_address_p;

    ddr_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0),
                       .MAX_OUTSTANDING(4), .CMD_RD(CMD_RD), .CMD_WR(CMD_WR)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a), .busy(busy_a),
        .err_orphan(err_a), .init_done(init_done), .cmd_busy(cmd_busy),
        .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data),
        .cmd(cmd_a), .cmd_valid(cmd_valid_a), .ddr_address(ddr_address_a),
        .ddr_wr_data(ddr_wr_data_a));

    ddr_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1),
                       .MAX_OUTSTANDING(4), .CMD_RD(CMD_RD), .CMD_WR(CMD_WR)) dut_p (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_p), .rd_valid(rd_valid_p), .rd_data(rd_data_p), .busy(busy_p),
        .err_orphan(err_p), .init_done(init_done), .cmd_busy(cmd_busy),
        .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data),
        .cmd(cmd_p), .cmd_valid(cmd_valid_p), .ddr_address(ddr_address_p),
        .ddr_wr_data(ddr_wr_data_p));

    int n_tests = 0;
    int n_fail  = 0;
    int exp_a[$];
    int exp_p[$];
    int rdq_a[$];
    int rdq_p[$];
    logic [DW-1:0] dq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        oh = NP'(1) << p;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        rnd128 = {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Bounded wait for an ack on dut_a; expiry is a counted failure.
    task automatic wait_ack(input int budget);
        int i;
        i = 0;
        while (ack_a == '0 && i < budget) begin
            tick();
            i++;
        end
        n_tests++;
        assert (ack_a !== '0) else begin
            n_fail++;
            $error("FAIL ack_timeout: observed %0h expected nonzero after %0d cycles", ack_a, budget);
        end
    endtask

    // Accept one read per iteration on both DUTs, then return one data word.
    task automatic grant_and_return(input int n);
        int pa, pp, ra, rp;
        logic [DW-1:0] d;
        for (int g = 0; g < n; g++) begin
            wait_ack(20);
            pa = exp_a.pop_front();
            pp = exp_p.pop_front();
            chk("rr_grant", 128'(ack_a), 128'(oh(pa)));
            chk("prio_grant", 128'(ack_p), 128'(oh(pp)));
            chk("rr_cmd_rd", 128'(cmd_a), 128'(CMD_RD));
            chk("rr_addr", 128'(ddr_address_a), 128'(AW'(32'h1000 + pa)));
            chk("prio_addr", 128'(ddr_address_p), 128'(AW'(32'h1000 + pp)));
            rdq_a.push_back(pa);
            rdq_p.push_back(pp);
            tick();
            d = rnd128();
            dq.push_back(d);
            ddr_rd_data    = d;
            ddr_data_valid = 1'b1;
            tick();
            ddr_data_valid = 1'b0;
            d  = dq.pop_front();
            ra = rdq_a.pop_front();
            rp = rdq_p.pop_front();
            chk("rr_rd_valid", 128'(rd_valid_a), 128'(oh(ra)));
            chk("rr_rd_data", rd_data_a, d);
            chk("prio_rd_valid", 128'(rd_valid_p), 128'(oh(rp)));
            chk("prio_rd_data", rd_data_p, d);
        end
    endtask

    initial begin
        logic [NP-1:0] seen;
        logic [DW-1:0] d;
        logic [DW-1:0] wd;

        rst = 1'b1; init_done = 1'b0; cmd_busy = 1'b0; ddr_data_valid = 1'b0;
        req = '0; we = '0; wdata = '0; ddr_rd_data = '0;
        for (int i = 0; i < NP; i++) addr[i*AW +: AW] = AW'(32'h1000 + i);

        // Reset state
        tick(); tick();
        chk("rst_ack", 128'(ack_a), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid_a), 128'(0));
        chk("rst_cmd_valid", 128'(cmd_valid_a), 128'(0));
        chk("rst_err", 128'(err_a), 128'(0));
        chk("rst_cmd", 128'(cmd_a), 128'(0));
        chk("rst_addr", 128'(ddr_address_a), 128'(0));
        chk("rst_wdata", ddr_wr_data_a, 128'(0));
        chk("rst_rd_data", rd_data_a, 128'(0));
        chk("rst_busy_no_init", 128'(busy_a), 128'(1));
        rst = 1'b0;

        // No selection while the controller is not initialised
        req = 4'b0001;
        seen = '0;
        repeat (5) begin tick(); seen |= ack_a | ack_p; end
        chk("no_issue_before_init", 128'(seen), 128'(0));
        req = '0;
        init_done = 1'b1;
        #1;
        chk("idle_busy", 128'(busy_a), 128'(0));

        // Single write on port 2, with the controller stalling one cycle
        wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        req = 4'b0100; we = 4'b0100;
        addr[2*AW +: AW]  = 25'h00ABC;
        wdata[2*DW +: DW] = wd;
        tick();
        cmd_busy = 1'b1;
        #1;
        chk("wr_latency_cmd_valid", 128'(cmd_valid_a), 128'(1));
        chk("wr_ack_held_busy", 128'(ack_a), 128'(0));
        chk("wr_cmd", 128'(cmd_a), 128'(CMD_WR));
        chk("wr_addr", 128'(ddr_address_a), 128'(25'h00ABC));
        chk("wr_data", ddr_wr_data_a, wd);
        tick();
        cmd_busy = 1'b0;
        #1;
        chk("wr_ack_a", 128'(ack_a), 128'(4'b0100));
        chk("wr_ack_p", 128'(ack_p), 128'(4'b0100));
        tick();
        req = '0; we = '0;
        addr[2*AW +: AW] = AW'(32'h1002);
        chk("wr_wait_cmd_valid", 128'(cmd_valid_a), 128'(0));
        chk("wr_wait_busy", 128'(busy_a), 128'(1));
        seen = '0;
        repeat (5) begin tick(); seen |= rd_valid_a | rd_valid_p; end
        chk("wr_no_rd_valid", 128'(seen), 128'(0));
        chk("wr_back_idle", 128'(busy_a), 128'(0));

        // All ports reading: round-robin rotates, fixed priority sticks at 0
        pulse_rst();
        req = 4'b1111; we = '0;
        foreach (exp_a[i]) ;
        exp_a.push_back(0); exp_a.push_back(1); exp_a.push_back(2);
        exp_a.push_back(3); exp_a.push_back(0); exp_a.push_back(1);
        repeat (6) exp_p.push_back(0);
        grant_and_return(6);
        // Port 0 drops out: priority moves to port 1, rr continues from last=1
        req = 4'b1110;
        exp_a.push_back(2); exp_a.push_back(3); exp_a.push_back(1);
        repeat (3) exp_p.push_back(1);
        grant_and_return(3);
        // Only port 3 left
        req = 4'b1000;
        repeat (2) begin exp_a.push_back(3); exp_p.push_back(3); end
        grant_and_return(2);
        req = '0;

        // Tag FIFO full: fifth read blocks, a write still goes through
        pulse_rst();
        req = 4'b0001; we = '0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(20);
            chk("fill_ack_a", 128'(ack_a), 128'(4'b0001));
            chk("fill_ack_p", 128'(ack_p), 128'(4'b0001));
            tick();
        end
        seen = '0;
        repeat (10) begin tick(); seen |= ack_a | ack_p; end
        chk("full_blocks_read", 128'(seen), 128'(0));
        wd = rnd128();
        wdata[1*DW +: DW] = wd;
        req = 4'b0011; we = 4'b0010;
        wait_ack(20);
        chk("full_wr_ack_a", 128'(ack_a), 128'(4'b0010));
        chk("full_wr_ack_p", 128'(ack_p), 128'(4'b0010));
        chk("full_wr_cmd", 128'(cmd_a), 128'(CMD_WR));
        chk("full_wr_data", ddr_wr_data_a, wd);
        req = 4'b0001; we = '0;
        tick();
        seen = '0;
        repeat (6) begin tick(); seen |= ack_a | ack_p; end
        chk("full_still_blocked", 128'(seen), 128'(0));
        d = rnd128();
        ddr_rd_data = d; ddr_data_valid = 1'b1;
        tick();
        ddr_data_valid = 1'b0;
        chk("full_pop_rd_valid", 128'(rd_valid_a), 128'(4'b0001));
        chk("full_pop_rd_data", rd_data_a, d);
        wait_ack(20);
        chk("fifth_read_ack", 128'(ack_a), 128'(4'b0001));
        chk("fifth_read_cmd", 128'(cmd_a), 128'(CMD_RD));
        req = '0;

        // Orphan data
        pulse_rst();
        ddr_rd_data = rnd128(); ddr_data_valid = 1'b1;
        tick();
        ddr_data_valid = 1'b0;
        chk("orphan_err_a", 128'(err_a), 128'(1));
        chk("orphan_err_p", 128'(err_p), 128'(1));
        chk("orphan_no_rd_valid", 128'(rd_valid_a | rd_valid_p), 128'(0));
        repeat (3) tick();
        chk("orphan_sticky", 128'(err_a), 128'(1));

        // Reset in WAIT with two tags pending
        pulse_rst();
        chk("rst_clears_err", 128'(err_a), 128'(0));
        req = 4'b0001; we = '0;
        wait_ack(20);
        tick();
        wait_ack(20);
        tick();
        chk("in_wait_busy", 128'(busy_a), 128'(1));
        rst = 1'b1; req = '0;
        tick();
        chk("midrst_ack", 128'(ack_a), 128'(0));
        chk("midrst_rd_valid", 128'(rd_valid_a), 128'(0));
        chk("midrst_cmd_valid", 128'(cmd_valid_a), 128'(0));
        chk("midrst_cmd", 128'(cmd_a), 128'(0));
        chk("midrst_addr", 128'(ddr_address_a), 128'(0));
        chk("midrst_err", 128'(err_a), 128'(0));
        chk("midrst_busy", 128'(busy_a), 128'(0));
        rst = 1'b0;
        ddr_rd_data = rnd128(); ddr_data_valid = 1'b1;
        tick();
        ddr_data_valid = 1'b0;
        chk("post_rst_orphan", 128'(err_a), 128'(1));
        chk("post_rst_no_rd_valid", 128'(rd_valid_a), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
